// File: rtl/wb_port_scheduler_pkg.sv
// wb_port_scheduler_pkg: shared widths and FSM encoding for the writeback port scheduler
//   REG_ADDR_W : register address width
//   XLEN_DEF   : default data width
//   state_t    : IDLE (buffer empty), HOLD (result buffered, waiting), FORCE (stall pipe, drain buffer)
package wb_port_scheduler_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN_DEF = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FORCE = 2'd2} state_t;
endpackage

// File: rtl/wb_port_scheduler_scoreboard.sv
// wb_scoreboard: per-register pending bits for long-latency destinations
//   clk, rst            : clock, async active-high reset
//   set_en, set_idx     : mark a register pending (wins over clear)
//   clr_en, clr_idx     : release a register once its result is written
//   idx1..idx3 / hit1..3: combinational lookups, index 0 never pending
//   pend                : full pending vector
module wb_scoreboard
  import wb_port_scheduler_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  input  logic [REG_ADDR_W-1:0] idx1,
  input  logic [REG_ADDR_W-1:0] idx2,
  input  logic [REG_ADDR_W-1:0] idx3,
  output logic                  hit1,
  output logic                  hit2,
  output logic                  hit3,
  output logic [NREG-1:0]       pend
);
  always_ff @(posedge clk or posedge rst)
    if (rst) pend <= '0;
    else begin
      if (clr_en) pend[clr_idx] <= 1'b0;
      if (set_en) pend[set_idx] <= 1'b1;
      pend[0] <= 1'b0;
    end
  assign hit1 = pend[idx1];
  assign hit2 = pend[idx2];
  assign hit3 = pend[idx3];
endmodule

// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler: arbitrates the single regfile write port between WB and a long-latency unit
//   pipe_*           : WB stage write request
//   iss_*            : long-latency issue, marks destination pending
//   lu_* / lu_ready  : long-unit result handshake, one-entry skid buffer behind it
//   id_* / id_stall  : decode RAW/WAW hazard lookup
//   force_stall      : WB must drop pipe_we so a starved buffered result can drain
//   rf_*             : regfile write port
//   WB_FWD_EN        : when defined, a source being written by the long unit this cycle does not stall
module wb_port_scheduler
  import wb_port_scheduler_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic                  id_stall,
  output logic                  force_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [REG_ADDR_W-1:0] buf_rd, waddr;
  logic [XLEN-1:0] buf_data, wdata;
  logic cap, ready, frc, pipe_wr, lu_wr, p1, p2, p3;
  logic [NREG-1:0] pend;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cap = 1'b0;
    ready = 1'b0;
    frc = 1'b0;
    pipe_wr = 1'b0;
    lu_wr = 1'b0;
    waddr = pipe_rd;
    wdata = pipe_data;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        pipe_wr = pipe_we;
        lu_wr = lu_valid && !pipe_we;
        if (lu_wr) begin
          waddr = lu_rd;
          wdata = lu_data;
        end
        if (lu_valid && pipe_we) begin
          cap = 1'b1;
          cnt_n = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        pipe_wr = pipe_we;
        lu_wr = !pipe_we;
        if (!pipe_we) begin
          waddr = buf_rd;
          wdata = buf_data;
          state_n = IDLE;
        end else if (int'(cnt) + 2 >= MAX_WAIT) state_n = FORCE;
        else cnt_n = cnt + 1'b1;
      end
      FORCE: begin
        frc = 1'b1;
        lu_wr = 1'b1;
        waddr = buf_rd;
        wdata = buf_data;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      buf_rd <= '0;
      buf_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (cap) begin
        buf_rd <= lu_rd;
        buf_data <= lu_data;
      end
    end
  // rst gating here keeps every output low for the whole reset, not just after the edge
  assign rf_we = !rst && (pipe_wr || lu_wr) && waddr != '0;
  assign rf_waddr = rf_we ? waddr : '0;
  assign rf_wdata = rf_we ? wdata : '0;
  assign lu_ready = !rst && ready;
  assign force_stall = !rst && frc;
  wb_scoreboard #(.NREG(NREG)) u_sb (
    .clk(clk), .rst(rst),
    .set_en(iss_valid && iss_rd != '0), .set_idx(iss_rd),
    .clr_en(rf_we && lu_wr), .clr_idx(waddr),
    .idx1(id_rs1), .idx2(id_rs2), .idx3(id_rd),
    .hit1(p1), .hit2(p2), .hit3(p3), .pend(pend)
  );
`ifdef WB_FWD_EN
  logic fwd;
  assign fwd = rf_we && lu_wr;
  assign id_stall = !rst && ((p1 && !(fwd && waddr == id_rs1)) || (p2 && !(fwd && waddr == id_rs2)) || p3);
`else
  assign id_stall = !rst && (p1 || p2 || p3);
`endif
  a_force_no_pipe: assert property (@(posedge clk) disable iff (rst) !(frc && pipe_we));
  a_no_waw: assert property (@(posedge clk) disable iff (rst) !(pipe_we && pend[pipe_rd]));
endmodule

// File: tb/tb_wb_port_scheduler.sv
// tb_wb_port_scheduler: randomized scoreboard bench for wb_port_scheduler
module tb_wb_port_scheduler;
  localparam int XLEN = 32;
  localparam int MAX_WAIT = 4;
  localparam int HOLD_LEN = (MAX_WAIT > 1) ? MAX_WAIT - 1 : 1;
  logic clk = 1'b0, rst = 1'b1;
  logic pipe_we = 0, iss_valid = 0, lu_valid = 0;
  logic [4:0] pipe_rd = 0, iss_rd = 0, lu_rd = 0, id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic [XLEN-1:0] pipe_data = 0, lu_data = 0;
  logic lu_ready, id_stall, force_stall, rf_we;
  logic [4:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  wb_port_scheduler #(.XLEN(XLEN), .NREG(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_ready(lu_ready), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_stall(id_stall),
    .force_stall(force_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );
  always #5 clk = ~clk;
  typedef struct {logic [4:0] a; logic [31:0] d; int c;} wr_t;
  wr_t exp_q[$];
  wr_t e;
  int checks = 0, fails = 0, cyc = 0;
  bit pend_m[32];
  bit have_buf = 0;
  logic [4:0] buf_rd = 0;
  logic [31:0] buf_d = 0;
  int age = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic clear_model();
    have_buf = 0;
    age = 0;
    foreach (pend_m[i]) pend_m[i] = 0;
    exp_q.delete();
  endtask
  task automatic step(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                      input logic iv, input logic [4:0] ird,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                      output logic acc);
    logic forced, w, luw, st;
    logic [4:0] wa;
    logic [31:0] wd;
    @(negedge clk);
    forced = have_buf && age >= HOLD_LEN;
    if (forced) pw = 0;
    pipe_we = pw; pipe_rd = prd; pipe_data = pd;
    iss_valid = iv; iss_rd = ird;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    id_rs1 = r1; id_rs2 = r2; id_rd = rdd;
    #1;
    cyc++;
    w = 1; luw = 1; wa = 0; wd = 0;
    if (have_buf && (forced || !pw)) begin wa = buf_rd; wd = buf_d; end
    else if (pw) begin luw = 0; wa = prd; wd = pd; end
    else if (lv) begin wa = lrd; wd = ld; end
    else begin w = 0; luw = 0; end
    st = (r1 != 0 && pend_m[r1]) || (r2 != 0 && pend_m[r2]) || (rdd != 0 && pend_m[rdd]);
    chk("lu_ready", lu_ready, !have_buf);
    chk("force_stall", force_stall, forced);
    chk("id_stall", id_stall, st);
    if (w && wa != 0) exp_q.push_back('{wa, wd, cyc});
    acc = lv && !have_buf;
    if (have_buf) begin
      if (forced || !pw) have_buf = 0;
      else age++;
    end else if (acc && pw) begin
      have_buf = 1; buf_rd = lrd; buf_d = ld; age = 0;
    end
    if (luw && wa != 0) pend_m[wa] = 0;
    if (iv && ird != 0) pend_m[ird] = 1;
  endtask
  task automatic idle(input logic [4:0] r1);
    logic a;
    step(0, 0, 0, 0, 0, 0, 0, 0, r1, 0, 0, a);
  endtask
  task automatic check_all_zero(input string n);
    chk({n, "_rf_we"}, rf_we, 0);
    chk({n, "_rf_waddr"}, rf_waddr, 0);
    chk({n, "_rf_wdata"}, rf_wdata, 0);
    chk({n, "_lu_ready"}, lu_ready, 0);
    chk({n, "_force_stall"}, force_stall, 0);
    chk({n, "_id_stall"}, id_stall, 0);
  endtask
  task automatic reset_hold();
    rst = 1;
    pipe_we = 0; iss_valid = 0; lu_valid = 0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL spurious_write: got addr %0d data %h expected no write (cycle %0d)", rf_waddr, rf_wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rf_waddr", rf_waddr, e.a);
          chk("rf_wdata", rf_wdata, e.d);
          chk("write_cycle", cyc, e.c);
        end
      end else if (exp_q.size() != 0 && exp_q[0].c <= cyc) begin
        e = exp_q.pop_front();
        checks++; fails++;
        $display("FAIL missing_write: got none expected addr %0d data %h (cycle %0d)", e.a, e.d, e.c);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    logic a, pw, iv, lv_h;
    logic [4:0] prd, ird, lrd_h;
    logic [31:0] ld_h;
    logic [4:0] cand[$];
    pipe_we = 1; pipe_rd = 4; lu_valid = 1; lu_rd = 6; id_rs1 = 6;
    #2;
    check_all_zero("reset");
    reset_hold();
    step(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, a);
    step(0, 0, 0, 0, 0, 1, 5, 32'h1234, 5, 0, 0, a);
    idle(5);
    step(1, 20, 32'hA0, 0, 0, 1, 7, 32'h77, 0, 0, 0, a);
    repeat (5) step(1, 21, $urandom, 0, 0, 0, 0, 0, 0, 0, 0, a);
    idle(0);
    step(1, 22, 32'hB0, 0, 0, 1, 8, 32'h88, 0, 0, 0, a);
    idle(0);
    idle(0);
    step(0, 0, 0, 1, 0, 1, 0, 32'hDEAD, 0, 0, 0, a);
    idle(0);
    step(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 1, 3, 1, 3, 32'h33, 0, 0, 0, a);
    idle(3);
    step(0, 0, 0, 0, 0, 1, 3, 32'h34, 3, 0, 0, a);
    idle(3);
    step(1, 23, 32'hC0, 0, 0, 1, 9, 32'h99, 0, 0, 0, a);
    @(posedge clk);
    #1 rst = 1;
    #1 check_all_zero("async_rst");
    reset_hold();
    idle(9);
    idle(9);
    lv_h = 0; lrd_h = 0; ld_h = 0;
    for (int i = 0; i < 1500; i++) begin
      pw = $urandom_range(0, 9) < 6;
      prd = 5'($urandom_range(0, 31));
      if (pend_m[prd]) prd = 0;
      ird = 5'($urandom_range(1, 31));
      iv = $urandom_range(0, 3) == 0 && !pend_m[ird];
      if (!lv_h && $urandom_range(0, 2) == 0) begin
        cand.delete();
        for (int r = 1; r < 32; r++) if (pend_m[r] && !(have_buf && buf_rd == 5'(r))) cand.push_back(5'(r));
        if (cand.size() > 0) begin
          lv_h = 1;
          lrd_h = cand[$urandom_range(0, cand.size() - 1)];
          ld_h = $urandom;
        end
      end
      step(pw, prd, $urandom, iv, ird, lv_h, lrd_h, ld_h, 5'($urandom), 5'($urandom), 5'($urandom), a);
      if (a) lv_h = 0;
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, lv_h, lrd_h, ld_h, 0, 0, 0, a);
      if (a) lv_h = 0;
    end
    @(negedge clk);
    #3;
    chk("expected_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
